// File: rtl/regfile_write_bank.sv
// Write side of the register file: predecoded 5-to-32 write enables, 32 x WIDTH storage.
// Ports: clk/reset, RegWrite/WriteRegister/WriteData, two combinational read ports, commit status flags.
module regfile_write_bank #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic              wr_done,
  output logic              wr_dropped,
  output logic [15:0]       wr_count
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int HI_W = ADDR_W / 2;
  localparam int LO_W = ADDR_W - HI_W;
  localparam int HI_N = 2 ** HI_W;
  localparam int LO_N = 2 ** LO_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [HI_N-1:0]  hi_dec;
  logic [LO_N-1:0]  lo_dec;
  logic [NREG-1:0]  en;
  logic [WIDTH-1:0] regs [NREG];
  logic             commit;
  logic             drop;

  // Two predecode stages; RegWrite gates the low stage so
  // every final AND already carries the write enable.
  always_comb begin
    hi_dec = '0;
    lo_dec = '0;
    hi_dec[WriteRegister[ADDR_W-1:LO_W]] = 1'b1;
    lo_dec[WriteRegister[LO_W-1:0]] = RegWrite;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_en
    localparam int HI_I = i / LO_N;
    localparam int LO_I = i % LO_N;
    if (i == ZERO_REG) begin : g_zero
      assign en[i] = 1'b0;
    end else begin : g_reg
      assign en[i] = hi_dec[HI_I] & lo_dec[LO_I];
    end
  end

  assign commit = |en;
  assign drop   = RegWrite & (WriteRegister == ZERO_IDX);

  // The zero register never has its enable set, so it
  // keeps the value it took at reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (en[i]) regs[i] <= WriteData;
    end
  end

  // Zero-register override is applied last so it also
  // masks the bypass path.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    if (BYPASS != 0 && RegWrite &&
        WriteRegister == ReadRegister1)
      ReadData1 = WriteData;
    if (ReadRegister1 == ZERO_IDX)
      ReadData1 = '0;
  end

  always_comb begin
    ReadData2 = regs[ReadRegister2];
    if (BYPASS != 0 && RegWrite &&
        WriteRegister == ReadRegister2)
      ReadData2 = WriteData;
    if (ReadRegister2 == ZERO_IDX)
      ReadData2 = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_done    <= 1'b0;
      wr_dropped <= 1'b0;
      wr_count   <= '0;
    end else begin
      wr_done    <= commit;
      wr_dropped <= drop;
      if (commit) wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the ARM processor register file.
- A 5-to-32 write decoder (one-hot enable per register, built from decoder stages) drives 32 x 64-bit registers.
- X31 is hardwired to zero.
- Two combinational read ports expose register contents to the existing mux read trees.
- Sits between the write-back stage and the read-operand muxes. Adds write-commit status flags for the pipeline control and the bench.

Parameters:
- WIDTH, 64, data width of each register.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- ZERO_REG, 31, index of the hardwired-zero register.
- BYPASS, 1, 1 = a read of the address being written this cycle returns WriteData; 0 = the read returns the stored (old) value.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- RegWrite  input  1  write enable for this cycle.
- WriteRegister  input  ADDR_W  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  ADDR_W  read port 1 index.
- ReadRegister2  input  ADDR_W  read port 2 index.
- ReadData1  output  WIDTH  read port 1 data (combinational).
- ReadData2  output  WIDTH  read port 2 data (combinational).
- wr_done  output  1  registered pulse, high for one cycle after a write commits.
- wr_dropped  output  1  registered pulse, high for one cycle after a write to ZERO_REG is discarded.
- wr_count  output  16  number of committed writes since reset.

Behaviour:
- Reset (synchronous, active-high):
  - All registers go to 0 on the posedge where reset = 1.
  - wr_done = 0, wr_dropped = 0, wr_count = 0.
  - Any write presented in the same cycle as reset is ignored; reset wins.
  - Reset asserted mid-sequence clears everything on that edge; there are no partial writes.
- Decoder:
  - en[i] = RegWrite & (WriteRegister == i), for i = 0 to 2**ADDR_W-1.
  - At most one en[i] is high in any cycle.
  - en[ZERO_REG] is forced to 0.
- Write:
  - On posedge clk, with reset = 0 and en[i] = 1, register i takes WriteData.
  - Write latency: the new value is visible on a non-bypassed read in the cycle after the edge.
- Zero register:
  - Reads of ZERO_REG always return 0, including through bypass.
  - Storage for ZERO_REG may be omitted or held at 0.
- Read ports:
  - Purely combinational. ReadDataN = reg[ReadRegisterN].
  - If BYPASS = 1, RegWrite = 1, WriteRegister == ReadRegisterN and ReadRegisterN != ZERO_REG, then ReadDataN = WriteData in that same cycle.
  - Both read ports may address the same register; both return the same value.
- Status flags (registered, valid the cycle after the write edge):
  - wr_done = 1 iff the previous edge committed a write, i.e. RegWrite & WriteRegister != ZERO_REG & !reset.
  - wr_dropped = 1 iff the previous edge had RegWrite & WriteRegister == ZERO_REG & !reset.
  - wr_done and wr_dropped are never both 1.
  - Back-to-back writes keep wr_done high on consecutive cycles.
- wr_count:
  - Increments by 1 on each committed write.
  - Wraps modulo 2**16: 0xFFFF + 1 becomes 0x0000.
  - Dropped writes do not increment it.
- Unknown or X inputs on RegWrite are not required to be handled; the bench drives only 0 or 1.

Test Plan:
- Reset then idle:
  - Hold reset high 2 cycles, release.
  - Read all 32 addresses on both ports → every ReadData = 0; wr_count = 0; wr_done = 0; wr_dropped = 0.
- Basic write and read-back:
  - Write 0x0123_4567_89AB_CDEF to X5, then read X5 on port 1 and X4 on port 2 next cycle.
  - Required: ReadData1 = 0x0123456789ABCDEF, ReadData2 = 0, wr_done = 1 for exactly one cycle, wr_count = 1.
- Zero register:
  - Write 0xFFFF_FFFF_FFFF_FFFF to X31, reading X31 on both ports during and after the write.
  - Required: ReadData1 = ReadData2 = 0 throughout; wr_dropped = 1 for one cycle; wr_count unchanged.
- Bypass:
  - X7 already holds 0x11. In one cycle write 0x22 to X7 while reading X7 on port 2.
  - BYPASS = 1: ReadData2 = 0x22 in that same cycle.
  - BYPASS = 0: ReadData2 = 0x11 in that cycle, then 0x22 next cycle.
- Decoder exhaustive sweep:
  - Write value (i+1)*0x1000 to each Xi for i = 0 to 30, then read all registers.
  - Required: Xi = (i+1)*0x1000, X31 = 0, no aliasing between registers, wr_count = 31.
- Reset collision:
  - Assert reset in the same cycle as a write of 0xAA to X3.
  - Required next cycle: X3 = 0, wr_done = 0, wr_count = 0, all other registers 0.
